// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq : staged domain-reset sequencer with PLL lock supervision
//
// Purpose
//   Sits in the system clock domain after the clock/reset generator. It
//   synchronizes the raw PLL lock indication and qualifies it over a window of
//   consecutive locked cycles. It then releases a set of active-low domain
//   resets one at a time, lowest bit first, with a fixed programmable gap
//   between them.
//   Once everything is released (RUN) it keeps watching lock. A filtered lock
//   loss pulls every domain back into reset and records the event.
//   A software reset request in RUN re-runs the staged release without
//   re-qualifying lock.
//
// Ports
//   clk_i         in   1         system clock
//   rst_i         in   1         synchronous active-high reset, overrides all
//   lock_i        in   1         raw PLL lock, asynchronous to clk_i
//   sw_rst_req_i  in   1         software reset request, one-cycle pulse
//   rst_n_o       out  N_STAGES  staged active-low resets, bit 0 released first
//   ready_o       out  1         all stages released and sequencer in RUN
//   lock_lost_o   out  1         sticky: lock was lost after release began
//   relock_cnt_o  out  8         saturating count of lock-loss events
//
// Parameters
//   SYNC_STAGES         synchronizer depth on lock_i (>= 2)
//   LOCK_STABLE_CYCLES  locked cycles counted in STABLE before release (>= 1)
//   STAGE_GAP           cycles between stage releases and software-reset
//                       hold length (>= 1)
//   N_STAGES            number of staged reset outputs (1..8)
//   LOSS_FILTER         consecutive unlocked cycles in RUN that count as a
//                       loss (>= 1)
// -----------------------------------------------------------------------------
module rst_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int N_STAGES           = 3,
  parameter int LOSS_FILTER        = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lock_i,
  input  logic                sw_rst_req_i,
  output logic [N_STAGES-1:0] rst_n_o,
  output logic                ready_o,
  output logic                lock_lost_o,
  output logic [7:0]          relock_cnt_o
);

  // One shared cycle counter serves the stability window, the inter-stage gap
  // and the software-reset hold. It only ever has to reach the larger of the
  // two programmable lengths minus one.
  localparam int CNT_SPAN = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int CNT_W    = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;
  localparam int SIDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int LOSS_W   = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

  localparam logic [CNT_W-1:0]    STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [SIDX_W-1:0]   STAGE_LAST  = SIDX_W'(N_STAGES - 1);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [N_STAGES-1:0] FIRST_STAGE = N_STAGES'(1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  // Saturating increment for the 8-bit loss-event counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    logic [7:0] res;
    if (val == 8'hFF) begin
      res = val;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

  // Next release pattern: shift in a one from the bottom. Bits can therefore
  // only become set in ascending order.
  function automatic logic [N_STAGES-1:0] release_next(input logic [N_STAGES-1:0] cur);
    return (cur << 1'b1) | FIRST_STAGE;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_t                 state_q,     state_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [SIDX_W-1:0]      stage_q,     stage_d;
  logic [LOSS_W-1:0]      loss_q,      loss_d;
  logic [N_STAGES-1:0]    rst_n_q,     rst_n_d;
  logic                   ready_q,     ready_d;
  logic                   lock_lost_q, lock_lost_d;
  logic [7:0]             relock_q,    relock_d;
  logic                   loss_evt_s;

  // Lock synchronizer: lock_i is asynchronous, so only the last flop is used.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock_i};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      stage_q     <= '0;
      loss_q      <= '0;
      rst_n_q     <= '0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      relock_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      loss_q      <= loss_d;
      rst_n_q     <= rst_n_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      relock_q    <= relock_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    loss_d      = loss_q;
    rst_n_d     = rst_n_q;
    ready_d     = ready_q;
    lock_lost_d = lock_lost_q;
    relock_d    = relock_q;
    loss_evt_s  = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        cnt_d   = '0;
        if (lock_s) begin
          state_d = ST_STABLE;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end

      ST_STABLE: begin
        // Dropping lock while qualifying only restarts qualification; it is
        // not a loss event because nothing has been released yet.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          stage_d = '0;
          rst_n_d = FIRST_STAGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        // Lock is unfiltered here: downstream domains are coming out of
        // reset and must not run on a suspect clock.
        if (!lock_s) begin
          loss_evt_s = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (stage_q == STAGE_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
            loss_d  = '0;
          end else begin
            stage_d = stage_q + 1'b1;
            rst_n_d = release_next(rst_n_q);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        // A filtered loss completing this cycle takes priority over a
        // simultaneous software request.
        if (!lock_s && (loss_q == LOSS_LAST)) begin
          loss_evt_s = 1'b1;
        end else if (sw_rst_req_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          loss_d  = '0;
          rst_n_d = '0;
          ready_d = 1'b0;
        end else if (!lock_s) begin
          loss_d = loss_q + 1'b1;
        end else begin
          loss_d = '0;
        end
      end

      ST_HOLD: begin
        // Lock was already qualified before RUN, so the hold exits straight
        // into a fresh staged release.
        if (!lock_s) begin
          loss_evt_s = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          stage_d = '0;
          rst_n_d = FIRST_STAGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
        stage_d = '0;
        loss_d  = '0;
        rst_n_d = '0;
        ready_d = 1'b0;
      end
    endcase

    // Common lock-loss action, shared by RELEASE, RUN and HOLD.
    if (loss_evt_s) begin
      state_d     = ST_WAIT_LOCK;
      cnt_d       = '0;
      stage_d     = '0;
      loss_d      = '0;
      rst_n_d     = '0;
      ready_d     = 1'b0;
      lock_lost_d = 1'b1;
      relock_d    = sat_inc8(relock_q);
    end else begin
      lock_lost_d = lock_lost_q;
    end
  end

  assign rst_n_o      = rst_n_q;
  assign ready_o      = ready_q;
  assign lock_lost_o  = lock_lost_q;
  assign relock_cnt_o = relock_q;

endmodule

// File: tb/tb_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_rst_seq : self-checking bench for rst_seq
//   Directed vector table (segments of constant input with expected outputs at
//   the end of each segment), hand-written corner sequences, then random
//   stimulus. Every cycle is also compared against a time-based reference
//   model.
// -----------------------------------------------------------------------------
module tb_rst_seq;

  localparam int SYNC = 2;
  localparam int LSC  = 8;
  localparam int GAP  = 4;
  localparam int NST  = 3;
  localparam int LF   = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           lock_i;
  logic           sw_rst_req_i;
  logic [NST-1:0] rst_n_o;
  logic           ready_o;
  logic           lock_lost_o;
  logic [7:0]     relock_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  rst_seq #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_GAP         (GAP),
    .N_STAGES          (NST),
    .LOSS_FILTER       (LF)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lock_i      (lock_i),
    .sw_rst_req_i(sw_rst_req_i),
    .rst_n_o     (rst_n_o),
    .ready_o     (ready_o),
    .lock_lost_o (lock_lost_o),
    .relock_cnt_o(relock_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model (time based) ----------------
  // Qualified release happens on the (LSC+1)-th consecutive synchronized-high
  // edge while idle. Once released, stage k is out of reset from t0+k*GAP and
  // ready from t0+NST*GAP. Everything is expressed as elapsed edges.
  typedef enum int {M_IDLE, M_REL, M_HOLD} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_n = 0, m_streak = 0, m_t0 = 0, m_hs = 0, m_low = 0, m_cnt = 0;
  bit     m_lost = 1'b0;
  bit     m_sync[$];

  task automatic model_edge(input logic l, input logic s, input logic r);
    bit ls;
    bit loss;
    m_n++;
    if (r) begin
      m_mode = M_IDLE; m_streak = 0; m_low = 0; m_lost = 1'b0; m_cnt = 0;
      m_sync.delete();
      for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b0);
    end else begin
      ls = m_sync.pop_front();
      m_sync.push_back(l);
      loss = 1'b0;
      case (m_mode)
        M_IDLE: begin
          m_streak = ls ? m_streak + 1 : 0;
          if (m_streak == LSC + 1) begin m_mode = M_REL; m_t0 = m_n; m_low = 0; end
        end
        M_REL: begin
          if ((m_n - 1 - m_t0) < NST * GAP) begin
            if (!ls) loss = 1'b1;
          end else begin
            m_low = ls ? 0 : m_low + 1;
            if (m_low == LF) loss = 1'b1;
            else if (s) begin m_mode = M_HOLD; m_hs = m_n; end
          end
        end
        default: begin
          if (!ls) loss = 1'b1;
          else if (m_n - m_hs == GAP) begin m_mode = M_REL; m_t0 = m_n; m_low = 0; end
        end
      endcase
      if (loss) begin
        m_mode = M_IDLE; m_streak = 0; m_lost = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [NST-1:0] er;
    logic           erdy;
    er   = '0;
    erdy = 1'b0;
    if (m_mode == M_REL) begin
      for (int k = 0; k < NST; k++) if ((m_n - m_t0) >= k * GAP) er[k] = 1'b1;
      erdy = ((m_n - m_t0) >= NST * GAP);
    end
    chk("model rst_n_o", 32'(rst_n_o), 32'(er));
    chk("model ready_o", 32'(ready_o), 32'(erdy));
    chk("model lock_lost_o", 32'(lock_lost_o), 32'(m_lost));
    chk("model relock_cnt_o", 32'(relock_cnt_o), 32'(m_cnt));
  endtask

  // One clock: drive inputs away from the edge, update model, sample after.
  task automatic cyc(input logic l, input logic s, input logic r);
    lock_i = l; sw_rst_req_i = s; rst_i = r;
    @(posedge clk_i);
    model_edge(l, s, r);
    #1;
    model_check();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic           lock;
    logic           sw;
    logic           rst;
    int             cycles;
    logic [NST-1:0] rst_n;
    logic           ready;
    logic           lost;
    logic [7:0]     cnt;
  } vec_t;

  function automatic vec_t mk(input logic l, input logic s, input logic r, input int c,
                              input logic [NST-1:0] rn, input logic rd, input logic lo,
                              input logic [7:0] cn);
    vec_t v;
    v.lock = l; v.sw = s; v.rst = r; v.cycles = c;
    v.rst_n = rn; v.ready = rd; v.lost = lo; v.cnt = cn;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    for (int i = 0; i < v.cycles; i++) cyc(v.lock, v.sw, v.rst);
    chk({tag, " rst_n_o"}, 32'(rst_n_o), 32'(v.rst_n));
    chk({tag, " ready_o"}, 32'(ready_o), 32'(v.ready));
    chk({tag, " lock_lost_o"}, 32'(lock_lost_o), 32'(v.lost));
    chk({tag, " relock_cnt_o"}, 32'(relock_cnt_o), 32'(v.cnt));
  endtask

  vec_t tbl[$];

  initial begin
    int cur_lock;
    int run_left;

    rst_i = 1'b1; lock_i = 1'b0; sw_rst_req_i = 1'b0;

    //                lock  sw    rst   cyc rst_n   rdy   lost  cnt
    // power-up qualification and staged release (T0 = edge 11)
    tbl.push_back(mk(1'b0, 1'b0, 1'b1,  2, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 10, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b001, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  3, 3'b001, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b011, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  4, 3'b111, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  3, 3'b111, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b111, 1'b1, 1'b0, 8'd0));
    // RUN: 3-cycle dropout ignored, 4-cycle dropout is a loss
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  3, 3'b111, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  6, 3'b111, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  4, 3'b111, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  1, 3'b111, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b1, 8'd1));
    // relock repeats the power-up timing
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 10, 3'b000, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b001, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 11, 3'b111, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b111, 1'b1, 1'b1, 8'd1));
    // software reset in RUN: hold GAP cycles, then release again
    tbl.push_back(mk(1'b1, 1'b1, 1'b0,  1, 3'b000, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  3, 3'b000, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b001, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  4, 3'b011, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  4, 3'b111, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  4, 3'b111, 1'b1, 1'b1, 8'd1));
    // rst_i in RUN clears sticky flag and count
    tbl.push_back(mk(1'b1, 1'b0, 1'b1,  1, 3'b000, 1'b0, 1'b0, 8'd0));
    // dropout during STABLE (cnt=5) restarts qualification, no loss counted
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  6, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  3, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 10, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b001, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 11, 3'b111, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b111, 1'b1, 1'b0, 8'd0));
    // loss, relock, then single-cycle dropout in RELEASE at 3'b011
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  6, 3'b000, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 10, 3'b000, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b001, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  4, 3'b011, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0,  1, 3'b011, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b011, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b1, 8'd2));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // Saturation: each 11-cycle period yields exactly one RELEASE-phase loss.
    for (int i = 0; i < 298; i++) begin
      for (int j = 0; j < 10; j++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    apply(mk(1'b1, 1'b0, 1'b0, 2, 3'b000, 1'b0, 1'b1, 8'd255), "saturate");

    // Filtered loss and software request on the same edge: loss wins.
    apply(mk(1'b1, 1'b0, 1'b1,  1, 3'b000, 1'b0, 1'b0, 8'd0), "simul rst");
    apply(mk(1'b1, 1'b0, 1'b0, 22, 3'b111, 1'b0, 1'b0, 8'd0), "simul qual");
    apply(mk(1'b1, 1'b0, 1'b0,  1, 3'b111, 1'b1, 1'b0, 8'd0), "simul run");
    apply(mk(1'b0, 1'b0, 1'b0,  5, 3'b111, 1'b1, 1'b0, 8'd0), "simul low");
    apply(mk(1'b0, 1'b1, 1'b0,  1, 3'b000, 1'b0, 1'b1, 8'd1), "simul both");
    apply(mk(1'b1, 1'b0, 1'b0,  6, 3'b000, 1'b0, 1'b1, 8'd1), "simul after");

    // Random phase, checked every cycle against the model.
    cyc(1'b1, 1'b0, 1'b1);
    cur_lock = 1;
    run_left = 30;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        cur_lock = 1 - cur_lock;
        run_left = (cur_lock == 1) ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 6));
      end
      run_left--;
      cyc(cur_lock[0], ($urandom_range(0, 15) == 0), ($urandom_range(0, 699) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
